// File: rtl/clock_setting_engine.sv
// clock_setting_engine: snapshots the live time or one alarm, edits it with inc/dec buttons
// (auto-repeat while held) and commits it on save; discards on mode exit or inactivity.
module clock_setting_engine #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int NUM_ALARMS      = 4,
  parameter int MAX_HOURS       = 24,
  parameter int MAX_MINUTES     = 60,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_S       = 10,
  localparam int HW = $clog2(MAX_HOURS),
  localparam int MW = $clog2(MAX_MINUTES),
  localparam int AW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HW-1:0]            cur_hours,
  input  logic [MW-1:0]            cur_minutes,
  input  logic [NUM_ALARMS*HW-1:0] alarm_hours_bus,
  input  logic [NUM_ALARMS*MW-1:0] alarm_minutes_bus,
  input  logic                     time_mode_switch,
  input  logic                     alarm_mode_switch,
  input  logic [AW-1:0]            alarm_sel,
  input  logic                     min_tens_switch,
  input  logic                     hours_tens_switch,
  input  logic                     save_btn,
  input  logic                     inc_min_btn,
  input  logic                     dec_min_btn,
  input  logic                     inc_hour_btn,
  input  logic                     dec_hour_btn,
  output logic [HW-1:0]            hours_settings,
  output logic [MW-1:0]            minutes_settings,
  output logic                     editing,
  output logic [AW-1:0]            edit_alarm_idx,
  output logic                     set_time,
  output logic                     set_alarm,
  output logic                     timeout
);
  localparam int DLY    = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RATE   = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int RMAX   = DLY > RATE ? DLY : RATE;
  localparam int RW     = $clog2(RMAX + 1);
  localparam int TO_CYC = TIMEOUT_S * CLK_HZ;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [MW:0] M_MOD = (MW+1)'(MAX_MINUTES);
  localparam logic [HW:0] H_MOD = (HW+1)'(MAX_HOURS);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_EDIT, ST_COMMIT, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic          alarm_q, alarm_d;
  logic [HW-1:0] hrs_q, hrs_d;
  logic [MW-1:0] min_q, min_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          timeout_q, timeout_d;
  logic          rep_on_q, rep_on_d, rep_first_q, rep_first_d;
  logic [1:0]    rep_btn_q, rep_btn_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [4:0]    s1_q, s2_q, h_q, press;
  logic [1:0]    win_sel, sel;
  logic          win_vld, held, rep_fire, exit_mode, step;
  logic [MW:0]   m_stp, m_sum;
  logic [HW:0]   h_stp, h_sum;

  // button order: inc_min, dec_min, inc_hour, dec_hour, save (index = step priority)
  assign press     = h_q & ~s2_q;
  assign win_vld   = |press[3:0];
  assign win_sel   = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
  assign held      = ~s2_q[rep_btn_q];
  assign rep_fire  = rep_cnt_q == (rep_first_q ? RW'(DLY - 1) : RW'(RATE - 1));
  assign exit_mode = alarm_q ? (!alarm_mode_switch || time_mode_switch)
                             : (!time_mode_switch || alarm_mode_switch);
  assign m_stp     = min_tens_switch ? (MW+1)'(10) : (MW+1)'(1);
  assign h_stp     = hours_tens_switch ? (HW+1)'(10) : (HW+1)'(1);

  always_comb begin
    state_d     = state_q;
    alarm_d     = alarm_q;
    hrs_d       = hrs_q;
    min_d       = min_q;
    idx_d       = idx_q;
    timeout_d   = 1'b0;
    rep_on_d    = 1'b0;
    rep_btn_d   = rep_btn_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    to_cnt_d    = '0;
    step        = 1'b0;
    sel         = win_sel;
    case (state_q)
      ST_IDLE: if (time_mode_switch ^ alarm_mode_switch) begin
        state_d = ST_LOAD;
        alarm_d = alarm_mode_switch;
      end
      ST_LOAD: begin
        state_d = ST_EDIT;
        hrs_d   = alarm_q ? alarm_hours_bus[alarm_sel*HW +: HW] : cur_hours;
        min_d   = alarm_q ? alarm_minutes_bus[alarm_sel*MW +: MW] : cur_minutes;
        idx_d   = alarm_q ? alarm_sel : idx_q;
      end
      ST_EDIT: begin
        rep_on_d = rep_on_q;
        if (exit_mode) state_d = ST_IDLE;
        else if (press[4]) state_d = ST_COMMIT;
        else begin
          if (win_vld) begin
            step        = 1'b1;
            rep_on_d    = 1'b1;
            rep_btn_d   = win_sel;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
          end else if (!rep_on_q || !held) rep_on_d = 1'b0;
          else if (rep_fire) begin
            step        = 1'b1;
            sel         = rep_btn_q;
            rep_first_d = 1'b0;
            rep_cnt_d   = '0;
          end else rep_cnt_d = rep_cnt_q + 1'b1;
          to_cnt_d = step ? '0 : to_cnt_q + 1'b1;
          if (!step && to_cnt_q == TW'(TO_CYC - 1)) begin
            state_d   = ST_WAIT;
            timeout_d = 1'b1;
          end
        end
      end
      ST_COMMIT: state_d = ST_WAIT;
      ST_WAIT: if (!time_mode_switch && !alarm_mode_switch) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // decrement is an add of the modular complement so one comparator handles wrap
    m_sum = {1'b0, min_q} + (sel[0] ? M_MOD - m_stp : m_stp);
    m_sum = m_sum >= M_MOD ? m_sum - M_MOD : m_sum;
    h_sum = {1'b0, hrs_q} + (sel[0] ? H_MOD - h_stp : h_stp);
    h_sum = h_sum >= H_MOD ? h_sum - H_MOD : h_sum;
    if (step && sel[1]) hrs_d = h_sum[HW-1:0];
    if (step && !sel[1]) min_d = m_sum[MW-1:0];
    if (state_d == ST_IDLE) begin
      hrs_d = '0;
      min_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      alarm_q     <= 1'b0;
      hrs_q       <= '0;
      min_q       <= '0;
      idx_q       <= '0;
      timeout_q   <= 1'b0;
      rep_on_q    <= 1'b0;
      rep_btn_q   <= '0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
      to_cnt_q    <= '0;
      s1_q        <= '1;
      s2_q        <= '1;
      h_q         <= '1;
    end else begin
      state_q     <= state_d;
      alarm_q     <= alarm_d;
      hrs_q       <= hrs_d;
      min_q       <= min_d;
      idx_q       <= idx_d;
      timeout_q   <= timeout_d;
      rep_on_q    <= rep_on_d;
      rep_btn_q   <= rep_btn_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
      to_cnt_q    <= to_cnt_d;
      s1_q        <= {save_btn, dec_hour_btn, inc_hour_btn, dec_min_btn, inc_min_btn};
      s2_q        <= s1_q;
      h_q         <= s2_q;
    end
  end

  assign hours_settings   = hrs_q;
  assign minutes_settings = min_q;
  assign edit_alarm_idx   = idx_q;
  assign editing          = state_q == ST_LOAD || state_q == ST_EDIT;
  assign set_time         = state_q == ST_COMMIT && !alarm_q;
  assign set_alarm        = state_q == ST_COMMIT && alarm_q;
  assign timeout          = timeout_q;
endmodule

// File: tb/tb_clock_setting_engine.sv
// tb_clock_setting_engine: directed vector table plus hand sequences for repeat, timeout,
// discard, held-on-entry and reset corner cases.
module tb_clock_setting_engine;
  localparam int HW = 5, MW = 6, AW = 2, NA = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic [HW-1:0] cur_hours = '0;
  logic [MW-1:0] cur_minutes = '0;
  logic [NA*HW-1:0] ahb = '0;
  logic [NA*MW-1:0] amb = '0;
  logic tsw = 1'b0, asw = 1'b0, mt = 1'b0, ht = 1'b0;
  logic [AW-1:0] asel = '0;
  logic save_b = 1'b1, inc_m = 1'b1, dec_m = 1'b1, inc_h = 1'b1, dec_h = 1'b1;
  logic [HW-1:0] hours_settings;
  logic [MW-1:0] minutes_settings;
  logic editing, set_time, set_alarm, timeout;
  logic [AW-1:0] edit_alarm_idx;
  int checks = 0, errors = 0, set_cnt = 0, n;

  clock_setting_engine #(
    .CLK_HZ(1000), .NUM_ALARMS(NA), .MAX_HOURS(24), .MAX_MINUTES(60),
    .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2), .TIMEOUT_S(1)
  ) dut (
    .clk(clk), .rst(rst), .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .alarm_hours_bus(ahb), .alarm_minutes_bus(amb),
    .time_mode_switch(tsw), .alarm_mode_switch(asw), .alarm_sel(asel),
    .min_tens_switch(mt), .hours_tens_switch(ht),
    .save_btn(save_b), .inc_min_btn(inc_m), .dec_min_btn(dec_m),
    .inc_hour_btn(inc_h), .dec_hour_btn(dec_h),
    .hours_settings(hours_settings), .minutes_settings(minutes_settings),
    .editing(editing), .edit_alarm_idx(edit_alarm_idx),
    .set_time(set_time), .set_alarm(set_alarm), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (set_time || set_alarm) set_cnt++;

  typedef struct {
    logic alarm; int sel; int sh; int sm; int btn; logic mt; logic ht; int eh; int em;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic val);
    case (b)
      0: inc_m = val;
      1: dec_m = val;
      2: inc_h = val;
      3: dec_h = val;
      default: save_b = val;
    endcase
  endtask

  task automatic chk_hm(input string name, input int h, input int m);
    chk({name, "_h"}, int'(hours_settings), h);
    chk({name, "_m"}, int'(minutes_settings), m);
  endtask

  task automatic enter_time(input int h, input int m);
    cur_hours = HW'(h);
    cur_minutes = MW'(m);
    tsw = 1'b1;
    tick(2);
  endtask

  task automatic leave;
    tsw = 1'b0;
    asw = 1'b0;
    tick(2);
  endtask

  initial begin
    int base;
    v[0] = '{1'b0, 0, 23, 59, 0, 1'b0, 1'b0, 23, 0};
    v[1] = '{1'b0, 0, 23, 0, 2, 1'b0, 1'b0, 0, 0};
    v[2] = '{1'b1, 2, 5, 7, 3, 1'b0, 1'b1, 19, 7};
    v[3] = '{1'b1, 2, 19, 7, 1, 1'b1, 1'b0, 19, 57};
    v[4] = '{1'b0, 0, 0, 0, 1, 1'b0, 1'b0, 0, 59};
    v[5] = '{1'b0, 0, 0, 5, 3, 1'b0, 1'b0, 23, 5};
    v[6] = '{1'b1, 0, 12, 55, 0, 1'b1, 1'b0, 12, 5};
    v[7] = '{1'b1, 3, 15, 30, 2, 1'b0, 1'b1, 1, 30};
    v[8] = '{1'b0, 0, 7, 3, 1, 1'b1, 1'b0, 7, 53};
    v[9] = '{1'b1, 1, 20, 0, 2, 1'b0, 1'b1, 6, 0};

    #2;
    chk_hm("reset", 0, 0);
    chk("reset_editing", int'(editing), 0);
    chk("reset_pulses", int'({set_time, set_alarm, timeout}), 0);
    chk("reset_idx", int'(edit_alarm_idx), 0);
    #20 rst = 1'b1;
    tick(2);

    foreach (v[i]) begin
      mt = v[i].mt;
      ht = v[i].ht;
      if (v[i].alarm) begin
        for (int k = 0; k < NA; k++) begin
          ahb[k*HW +: HW] = HW'(k + 1);
          amb[k*MW +: MW] = MW'(k + 40);
        end
        ahb[v[i].sel*HW +: HW] = HW'(v[i].sh);
        amb[v[i].sel*MW +: MW] = MW'(v[i].sm);
        asel = AW'(v[i].sel);
        asw = 1'b1;
        tick(2);
      end else enter_time(v[i].sh, v[i].sm);
      chk("vec_editing", int'(editing), 1);
      chk_hm("vec_snapshot", v[i].sh, v[i].sm);
      asel = asel + 1'b1;
      cur_hours = '0;
      set_btn(v[i].btn, 1'b0);
      tick(3);
      chk_hm("vec_step", v[i].eh, v[i].em);
      set_btn(v[i].btn, 1'b1);
      tick(3);
      chk_hm("vec_no_repeat", v[i].eh, v[i].em);
      base = set_cnt;
      set_btn(4, 1'b0);
      tick(3);
      chk("vec_set_time", int'(set_time), int'(!v[i].alarm));
      chk("vec_set_alarm", int'(set_alarm), int'(v[i].alarm));
      chk_hm("vec_commit", v[i].eh, v[i].em);
      if (v[i].alarm) chk("vec_idx", int'(edit_alarm_idx), v[i].sel);
      tick(1);
      chk("vec_pulse_width", set_cnt - base, 1);
      chk("vec_wait_editing", int'(editing), 0);
      chk_hm("vec_wait_hold", v[i].eh, v[i].em);
      set_btn(4, 1'b1);
      leave();
      chk_hm("vec_idle", 0, 0);
      tick(3);
    end
    mt = 1'b0;
    ht = 1'b0;

    // auto-repeat: press step, then steps 5, 7 and 9 cycles later
    enter_time(10, 0);
    inc_m = 1'b0;
    tick(3);
    chk_hm("rep_press", 10, 1);
    tick(4);
    chk_hm("rep_before_delay", 10, 1);
    tick(1);
    chk_hm("rep_first", 10, 2);
    tick(2);
    chk_hm("rep_second", 10, 3);
    tick(1);
    inc_m = 1'b1;
    tick(1);
    chk_hm("rep_third", 10, 4);
    tick(5);
    chk_hm("rep_released", 10, 4);
    leave();

    // simultaneous presses: inc_min wins, inc_hour edge is dropped
    enter_time(8, 30);
    inc_m = 1'b0;
    inc_h = 1'b0;
    tick(3);
    chk_hm("simul", 8, 31);
    inc_m = 1'b1;
    inc_h = 1'b1;
    tick(8);
    chk_hm("simul_after", 8, 31);
    leave();

    // button held across entry does not step until re-pressed
    inc_m = 1'b0;
    tick(3);
    enter_time(4, 20);
    tick(10);
    chk_hm("held_entry", 4, 20);
    inc_m = 1'b1;
    tick(3);
    inc_m = 1'b0;
    tick(3);
    chk_hm("held_repress", 4, 21);
    inc_m = 1'b1;
    tick(3);
    leave();

    // inactivity timeout
    base = set_cnt;
    cur_hours = 5'd3;
    cur_minutes = 6'd4;
    tsw = 1'b1;
    n = 0;
    while (!editing && n < 5) begin
      tick(1);
      n++;
    end
    chk("to_enter", int'(editing), 1);
    n = 0;
    while (!timeout && n < 1200) begin
      tick(1);
      n++;
    end
    chk("to_latency", n, 1001);
    chk("to_no_commit", set_cnt - base, 0);
    tick(1);
    chk("to_pulse_width", int'(timeout), 0);
    tick(20);
    chk("to_wait_editing", int'(editing), 0);
    chk_hm("to_wait_hold", 3, 4);
    cur_hours = 5'd11;
    cur_minutes = 6'd11;
    tsw = 1'b0;
    tick(2);
    enter_time(11, 11);
    chk_hm("to_reload", 11, 11);
    leave();

    // mode exit discards the edit
    base = set_cnt;
    enter_time(12, 33);
    inc_m = 1'b0;
    tick(3);
    chk_hm("discard_edit", 12, 34);
    inc_m = 1'b1;
    tick(3);
    tsw = 1'b0;
    tick(1);
    chk_hm("discard", 0, 0);
    chk("discard_editing", int'(editing), 0);
    chk("discard_no_commit", set_cnt - base, 0);
    tick(2);

    // reset mid-edit, then both switches high
    base = set_cnt;
    enter_time(5, 6);
    rst = 1'b0;
    #1;
    chk_hm("rst_mid", 0, 0);
    chk("rst_mid_editing", int'(editing), 0);
    asw = 1'b1;
    #3 rst = 1'b1;
    tick(5);
    chk("conflict_editing", int'(editing), 0);
    chk_hm("conflict", 0, 0);
    chk("rst_no_commit", set_cnt - base, 0);
    leave();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
